// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART transmit controller.
//   state_e         : controller FSM states
//   DEFAULT_DEPTH   : default byte FIFO depth
//   DEFAULT_TIMEOUT : default WAIT cycle budget before abort
//   cnt_width()     : counter width able to hold 0..n-1 (at least 1 bit)
package uart_ctrl_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned DEFAULT_DEPTH   = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmit controller.
//   push_i/push_data_i : enqueue a byte (dropped when full unless a pop happens too)
//   pop_i/pop_data_c   : dequeue; pop_data_c is the current head (combinational)
//   flush_i            : empty the FIFO on the next edge, beats a same-cycle push
//   full_o/empty_o     : registered status
//   level_o            : registered occupancy, 0..DEPTH
//   drop_c             : a push was rejected this cycle
module uart_tx_fifo
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       push_data_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic [DATA_W-1:0]       pop_data_c,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok, pop_ok;

  // Pointer/level update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    pop_ok     = pop_i && !empty_q;
    push_ok    = push_i && !flush_i && (!full_q || pop_ok);
    drop_c     = push_i && !flush_i && full_q && !pop_ok;
    pop_data_c = mem_q[rd_ptr_q];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// CPU-side transmit controller: queues bytes and hands them one at a time
// to a UART TX core with a start/done handshake and a WAIT timeout.
//   wr_en_i/wr_data_i : CPU byte write
//   flush_i           : drop queued bytes (in-flight byte continues)
//   clr_err_i         : clear sticky ovf_o/tout_o
//   tx_done_i         : TX core finished the current byte
//   tx_data_o/tx_start_o/send_o : handshake to the TX core
//   full_o/empty_o/level_o      : FIFO status
//   ovf_o/tout_o                : sticky overflow / timeout flags
module uart_tx_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wr_en_i,
  input  logic [7:0]             wr_data_i,
  input  logic                   flush_i,
  input  logic                   clr_err_i,
  input  logic                   tx_done_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  output logic                   send_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   ovf_o,
  output logic                   tout_o
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              send_q, send_d;
  logic              ovf_q, ovf_d;
  logic              tout_q, tout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pop_c;
  logic              tout_hit_c;
  logic [DATA_W-1:0] fifo_data_c;
  logic              fifo_drop_c;
  logic              fifo_full, fifo_empty;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (wr_en_i),
    .push_data_i (wr_data_i),
    .pop_i       (pop_c),
    .flush_i     (flush_i),
    .pop_data_c  (fifo_data_c),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level_o),
    .drop_c      (fifo_drop_c)
  );

  // WAIT budget exhausted with no completion this cycle.
  assign tout_hit_c = (state_q == ST_WAIT) && !tx_done_i && (cnt_q == CNT_LAST);

  // State and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      send_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tout_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      send_q     <= send_d;
      ovf_q      <= ovf_d;
      tout_q     <= tout_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic. A flush landing between IDLE and LOAD leaves nothing
  // to send, so LOAD falls back to IDLE instead of starting a stale byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD:  state_d = fifo_empty ? ST_IDLE : ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (tx_done_i || tout_hit_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; outputs are registered so tx_start_o
  // is high during START and send_o covers START and WAIT.
  always_comb begin
    pop_c      = 1'b0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    cnt_d      = '0;
    ovf_d      = ovf_q;
    tout_d     = tout_q;
    if (state_q == ST_LOAD && !fifo_empty) begin
      pop_c      = 1'b1;
      tx_data_d  = fifo_data_c;
      tx_start_d = 1'b1;
    end
    send_d = (state_d == ST_START) || (state_d == ST_WAIT);
    if (state_q == ST_WAIT) cnt_d = cnt_q + CNT_W'(1);
    // A new error in the same cycle as a clear keeps the flag set.
    if (clr_err_i) begin
      ovf_d  = 1'b0;
      tout_d = 1'b0;
    end
    if (fifo_drop_c) ovf_d  = 1'b1;
    if (tout_hit_c)  tout_d = 1'b1;
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign send_o     = send_q;
  assign ovf_o      = ovf_q;
  assign tout_o     = tout_q;
  assign full_o     = fifo_full;
  assign empty_o    = fifo_empty;

endmodule
